riscv_if_fetchq: RTL and testbench

Next-generation instruction fetch stage. It decouples ICACHE word fetches from instruction issue with a parametrised halfword-granular prefetch queue. The queue extracts 16-bit (RVC) and 32-bit instructions at any halfword alignment. Handles redirects while a cache miss is outstanding, and drives the IF/ID pipeline registers (inst_ppl, pc_ppl, compressed_ppl) consumed by decode.

---
 rtl/riscv_if_fetchq.sv | 183 ++++++++++++++++++
 tb/tb_riscv_if_fetchq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_if_fetchq.sv
// Instruction fetch stage: halfword prefetch queue between ICACHE word fetches and the IF/ID
// registers, extracting 16/32-bit instructions at any halfword alignment.
module riscv_if_fetchq #(
    parameter int          QDEPTH     = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ENABLE_RVC = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        make_correction,
    input  logic [31:0]                 pc_correction,
    input  logic                        ICACHE_stall,
    output logic                        ICACHE_ren,
    output logic                        ICACHE_wen,
    output logic [29:0]                 ICACHE_addr,
    input  logic [31:0]                 ICACHE_rdata,
    output logic [31:0]                 ICACHE_wdata,
    output logic [31:0]                 inst_ppl,
    output logic [31:0]                 pc_ppl,
    output logic                        compressed_ppl,
    output logic [31:0]                 PC,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int          PW  = $clog2(QDEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           ren_q, ren_d;
    logic [29:0]    addr_q, addr_d;
    logic [29:0]    fpc_q, fpc_d;
    logic           drop_low_q, drop_low_d;
    logic [31:0]    head_pc_q, head_pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [15:0]    mem_q [QDEPTH];
    logic [15:0]    mem_d [QDEPTH];
    logic [31:0]    inst_ppl_q, inst_ppl_d;
    logic [31:0]    pc_ppl_q, pc_ppl_d;
    logic           compressed_ppl_q, compressed_ppl_d;

    logic [15:0]    h0, h1;
    logic           is_rvc, avail, do_pop, do_push, complete, outstanding;
    logic [CW-1:0]  pop_n, push_n;

    always_comb begin
        h0          = mem_q[rd_ptr_q];
        h1          = mem_q[rd_ptr_q + PW'(1)];
        is_rvc      = (ENABLE_RVC != 0) && (h0[1:0] != 2'b11);
        avail       = is_rvc ? (count_q >= CW'(1)) : (count_q >= CW'(2));
        do_pop      = !stall && avail && !make_correction;
        pop_n       = do_pop ? (is_rvc ? CW'(1) : CW'(2)) : CW'(0);
        complete    = ren_q && !ICACHE_stall;
        outstanding = ren_q && ICACHE_stall;
        do_push     = complete && (state_q == FETCH) && !make_correction;
        push_n      = do_push ? (drop_low_q ? CW'(1) : CW'(2)) : CW'(0);
    end

    // Queue storage, pointers and PC state; a correction wipes the queue and cancels push/pop.
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        head_pc_d  = head_pc_q;
        fpc_d      = fpc_q;
        drop_low_d = drop_low_q;
        count_d    = count_q + push_n - pop_n;

        if (do_push) begin
            fpc_d = fpc_q + 30'd1;
            if (drop_low_q) begin
                mem_d[wr_ptr_q] = ICACHE_rdata[31:16];
                wr_ptr_d        = wr_ptr_q + PW'(1);
                drop_low_d      = 1'b0;
            end else begin
                mem_d[wr_ptr_q]          = ICACHE_rdata[15:0];
                mem_d[wr_ptr_q + PW'(1)] = ICACHE_rdata[31:16];
                wr_ptr_d                 = wr_ptr_q + PW'(2);
            end
        end

        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + pop_n[PW-1:0];
            head_pc_d = head_pc_q + (is_rvc ? 32'd2 : 32'd4);
        end

        if (make_correction) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            head_pc_d  = pc_correction;
            fpc_d      = pc_correction[31:2];
            drop_low_d = pc_correction[1];
        end
    end

    // Request FSM: ren/addr are frozen while a request is outstanding; a new request only
    // issues when the queue can absorb a whole word after any pops in flight.
    always_comb begin
        state_d = state_q;
        ren_d   = ren_q;
        addr_d  = addr_q;
        if (outstanding) begin
            if (make_correction) begin
                state_d = DROP;
            end
        end else begin
            state_d = FETCH;
            ren_d   = (count_d <= CW'(QDEPTH - 2));
            addr_d  = fpc_d;
        end
    end

    always_comb begin
        inst_ppl_d       = inst_ppl_q;
        pc_ppl_d         = pc_ppl_q;
        compressed_ppl_d = compressed_ppl_q;
        if (!stall) begin
            pc_ppl_d = head_pc_q;
            if (flush || !avail) begin
                inst_ppl_d       = NOP;
                compressed_ppl_d = 1'b0;
            end else begin
                inst_ppl_d       = is_rvc ? {16'h0000, h0} : {h1, h0};
                compressed_ppl_d = is_rvc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= FETCH;
            ren_q            <= 1'b0;
            addr_q           <= RESET_PC[31:2];
            fpc_q            <= RESET_PC[31:2];
            drop_low_q       <= 1'b0;
            head_pc_q        <= RESET_PC;
            count_q          <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            inst_ppl_q       <= 32'h0000_0000;
            pc_ppl_q         <= 32'h0000_0000;
            compressed_ppl_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            ren_q            <= ren_d;
            addr_q           <= addr_d;
            fpc_q            <= fpc_d;
            drop_low_q       <= drop_low_d;
            head_pc_q        <= head_pc_d;
            count_q          <= count_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            mem_q            <= mem_d;
            inst_ppl_q       <= inst_ppl_d;
            pc_ppl_q         <= pc_ppl_d;
            compressed_ppl_q <= compressed_ppl_d;
        end
    end

    assign ICACHE_ren     = ren_q;
    assign ICACHE_wen     = 1'b0;
    assign ICACHE_addr    = addr_q;
    assign ICACHE_wdata   = 32'h0000_0000;
    assign inst_ppl       = inst_ppl_q;
    assign pc_ppl         = pc_ppl_q;
    assign compressed_ppl = compressed_ppl_q;
    assign PC             = head_pc_q;
    assign q_count        = count_q;

endmodule

// File: tb/tb_riscv_if_fetchq.sv
// Testbench for riscv_if_fetchq: ISA-level scoreboard of issued instructions against a
// word-addressed instruction memory, plus directed redirect/miss/stall/flush/reset steps.
module tb_riscv_if_fetchq;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        make_correction;
    logic [31:0] pc_correction;
    logic        icache_stall;
    logic        icache_ren;
    logic        icache_wen;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic [31:0] icache_wdata;
    logic [31:0] inst_ppl;
    logic [31:0] pc_ppl;
    logic        compressed_ppl;
    logic [31:0] pc_head;
    logic [3:0]  q_count;

    logic [31:0] imem [1024];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        comp;
        logic [31:0] len;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    exp_t fl_e;
    logic last_stall;
    int   checks;
    int   errors;

    riscv_if_fetchq #(
        .QDEPTH(8),
        .RESET_PC(32'h0000_0000),
        .ENABLE_RVC(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .flush(flush),
        .make_correction(make_correction),
        .pc_correction(pc_correction),
        .ICACHE_stall(icache_stall),
        .ICACHE_ren(icache_ren),
        .ICACHE_wen(icache_wen),
        .ICACHE_addr(icache_addr),
        .ICACHE_rdata(icache_rdata),
        .ICACHE_wdata(icache_wdata),
        .inst_ppl(inst_ppl),
        .pc_ppl(pc_ppl),
        .compressed_ppl(compressed_ppl),
        .PC(pc_head),
        .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign icache_rdata = imem[icache_addr[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = imem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction stream a correct fetch unit must issue starting at 'start'
    task automatic pushExpected(input logic [31:0] start, input int n);
        exp_t        e;
        logic [31:0] pc;
        logic [15:0] h0;
        pc = start;
        for (int i = 0; i < n; i++) begin
            h0   = hw(pc);
            e.pc = pc;
            if (h0[1:0] != 2'b11) begin
                e.inst = {16'h0000, h0};
                e.comp = 1'b1;
                e.len  = 32'd2;
            end else begin
                e.inst = {hw(pc + 32'd2), h0};
                e.comp = 1'b0;
                e.len  = 32'd4;
            end
            sb.push_back(e);
            pc = pc + e.len;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (rst_n && !last_stall && inst_ppl !== NOP) begin
            if (sb.size() == 0) begin
                check("unexpected_issue_pc", pc_ppl, 32'hFFFF_FFFF);
            end else begin
                e      = sb.pop_front();
                last_e = e;
                check("inst_ppl", inst_ppl, e.inst);
                check("pc_ppl", pc_ppl, e.pc);
                check("compressed_ppl", 32'(compressed_ppl), 32'(e.comp));
                check("PC_after_issue", pc_head, e.pc + e.len);
            end
        end
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic mc,
                                 input logic [31:0] pcc, input logic ics);
        stall           = st;
        flush           = fl;
        make_correction = mc;
        pc_correction   = pcc;
        icache_stall    = ics;
        @(posedge clk);
        #1;
        last_stall = st;
        checkOutput();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        check("scoreboard_drained_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic checkReset();
        check("rst_inst_ppl", inst_ppl, 32'h0);
        check("rst_pc_ppl", pc_ppl, 32'h0);
        check("rst_compressed", 32'(compressed_ppl), 32'd0);
        check("rst_ren", 32'(icache_ren), 32'd0);
        check("rst_wen", 32'(icache_wen), 32'd0);
        check("rst_wdata", icache_wdata, 32'h0);
        check("rst_PC", pc_head, 32'h0);
        check("rst_q_count", 32'(q_count), 32'd0);
    endtask

    initial begin
        int n;
        checks          = 0;
        errors          = 0;
        last_stall      = 1'b0;
        rst_n           = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        make_correction = 1'b0;
        pc_correction   = 32'h0;
        icache_stall    = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            imem[i] = {i[11:0], 20'h00093};
        end
        imem[0]   = 32'h0010_0093;
        imem[1]   = 32'h0020_0113;
        imem[256] = 32'h0093_0505;
        imem[257] = 32'h4501_0010;

        repeat (2) @(posedge clk);
        #1;
        checkReset();

        $display("[TB] straight-line 32-bit code from reset");
        pushExpected(32'h0, 6);
        rst_n = 1'b1;
        drain(60);

        $display("[TB] correction to misaligned 0x102");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
        check("corr_ren", 32'(icache_ren), 32'd1);
        check("corr_addr", {2'b00, icache_addr}, 32'h40);
        check("corr_PC", pc_head, 32'h102);
        check("corr_q_count", 32'(q_count), 32'd0);
        check("corr_inst_nop", inst_ppl, NOP);
        pushExpected(32'h0000_0102, 6);
        drain(60);

        $display("[TB] mixed RVC with split 32-bit instruction");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
        pushExpected(32'h0000_0400, 5);
        drain(60);

        $display("[TB] correction during outstanding miss");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
        check("miss_issue_addr", {2'b00, icache_addr}, 32'h10);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("miss_hold_ren", 32'(icache_ren), 32'd1);
            check("miss_hold_addr", {2'b00, icache_addr}, 32'h10);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b1);
        check("drop_ren", 32'(icache_ren), 32'd1);
        check("drop_addr", {2'b00, icache_addr}, 32'h10);
        check("drop_PC", pc_head, 32'h800);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("drop_hold_addr", {2'b00, icache_addr}, 32'h10);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("after_drop_ren", 32'(icache_ren), 32'd1);
        check("after_drop_addr", {2'b00, icache_addr}, 32'h200);
        check("after_drop_q_count", 32'(q_count), 32'd0);
        pushExpected(32'h0000_0800, 5);
        drain(60);

        $display("[TB] downstream stall saturates the queue");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0C00, 1'b0);
        pushExpected(32'h0000_0C00, 14);
        n = 0;
        while (sb.size() > 12 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        check("pre_stall_issued_left", 32'(sb.size()), 32'd12);
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_inst_frozen", inst_ppl, last_e.inst);
        check("stall_pc_frozen", pc_ppl, last_e.pc);
        check("stall_q_full", 32'(q_count), 32'd8);
        check("stall_ren_off", 32'(icache_ren), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] flush discards the head instruction");
        fl_e = sb.pop_front();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("flush_inst_nop", inst_ppl, NOP);
        check("flush_compressed", 32'(compressed_ppl), 32'd0);
        check("flush_pc_ppl", pc_ppl, fl_e.pc);
        check("flush_PC_advanced", pc_head, fl_e.pc + fl_e.len);
        drain(60);

        $display("[TB] async reset during a miss");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #2;
        checkReset();
        @(posedge clk);
        #1;
        icache_stall = 1'b0;
        pushExpected(32'h0, 4);
        rst_n = 1'b1;
        drain(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
